// File: rtl/load_store_unit.sv
// load_store_unit: RV32I byte/half/word loads and stores over a word-only RAM port, with read-modify-write for sub-word stores.
// Optional LSU_ERR_EN: flag misaligned/illegal requests on resp_err instead of normalising them.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_store,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
`ifdef LSU_ERR_EN
  output logic                  resp_err,
`endif
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_write_data,
  input  logic [31:0]           mem_read_data
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, RESP} state_t;
  state_t state_q, state_d;
  logic store_q, store_d;
  logic [2:0] funct3_q, funct3_d;
  logic [1:0] lane_q, lane_d;
  logic [15:0] wdata_q, wdata_d;
  logic mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
  logic [31:0] mem_write_data_q, mem_write_data_d, rdata_q, rdata_d;
  logic resp_valid_q, resp_valid_d;
  logic legal, bad, sw;
  logic [2:0] f3;
  logic [ADDR_WIDTH-1:0] addr;
  logic [7:0] rd_byte;
  logic [15:0] rd_half;
  logic [31:0] merged, loaded;
`ifdef LSU_ERR_EN
  logic err_q, err_d;
`endif

  // Classify the incoming request; without error reporting, illegal codes fall back to word access and addresses snap to natural alignment
  always_comb begin
    legal = req_store ? (req_funct3 <= 3'd2) : (req_funct3 != 3'd3 && req_funct3 <= 3'd5);
`ifdef LSU_ERR_EN
    f3 = req_funct3;
    addr = req_addr;
    bad = !legal || (f3[1:0] == 2'd1 && req_addr[0]) || (f3[1:0] == 2'd2 && req_addr[1:0] != 2'd0);
`else
    f3 = legal ? req_funct3 : 3'b010;
    addr = {req_addr[ADDR_WIDTH-1:2], f3[1] ? 2'b00 : {req_addr[1], req_addr[0] & ~f3[0]}};
    bad = 1'b0;
`endif
    sw = req_store && f3[1];
  end

  // Lane extraction and extension for loads, lane merge for sub-word stores
  always_comb begin
    rd_byte = mem_read_data[{lane_q, 3'b000} +: 8];
    rd_half = lane_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    merged = mem_read_data;
    if (funct3_q[0]) merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
    else merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    loaded = funct3_q[1] ? mem_read_data :
             funct3_q[0] ? {{16{~funct3_q[2] & rd_half[15]}}, rd_half} :
                           {{24{~funct3_q[2] & rd_byte[7]}}, rd_byte};
  end

  // Next-state and next-output logic; RAM strobes are registered so they are asserted while in ISSUE/WRITE
  always_comb begin
    state_d = state_q;
    store_d = store_q;
    funct3_d = funct3_q;
    lane_d = lane_q;
    wdata_d = wdata_q;
    mem_read_d = 1'b0;
    mem_write_d = 1'b0;
    mem_address_d = mem_address_q;
    mem_write_data_d = mem_write_data_q;
    rdata_d = rdata_q;
    resp_valid_d = resp_valid_q;
`ifdef LSU_ERR_EN
    err_d = err_q;
`endif
    case (state_q)
      IDLE: if (req_valid) begin
        store_d = req_store;
        funct3_d = f3;
        lane_d = addr[1:0];
        wdata_d = req_wdata[15:0];
        rdata_d = '0;
`ifdef LSU_ERR_EN
        err_d = bad;
`endif
        state_d = bad ? RESP : ISSUE;
        resp_valid_d = bad;
        if (!bad) begin
          mem_address_d = {addr[ADDR_WIDTH-1:2], 2'b00};
          mem_write_data_d = req_wdata;
          mem_write_d = sw;
          mem_read_d = !sw;
        end
      end
      ISSUE: begin
        state_d = (store_q && funct3_q[1]) ? RESP : WAIT;
        resp_valid_d = store_q && funct3_q[1];
      end
      WAIT: begin
        state_d = store_q ? WRITE : RESP;
        resp_valid_d = !store_q;
        mem_write_d = store_q;
        mem_write_data_d = store_q ? merged : mem_write_data_q;
        rdata_d = store_q ? '0 : loaded;
      end
      WRITE: begin
        state_d = RESP;
        resp_valid_d = 1'b1;
      end
      RESP: if (resp_ready) begin
        state_d = IDLE;
        resp_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset clears strobes at once so an interrupted WRITE never reaches the RAM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      store_q <= 1'b0;
      funct3_q <= '0;
      lane_q <= '0;
      wdata_q <= '0;
      mem_read_q <= 1'b0;
      mem_write_q <= 1'b0;
      mem_address_q <= '0;
      mem_write_data_q <= '0;
      rdata_q <= '0;
      resp_valid_q <= 1'b0;
`ifdef LSU_ERR_EN
      err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      funct3_q <= funct3_d;
      lane_q <= lane_d;
      wdata_q <= wdata_d;
      mem_read_q <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_write_data_q <= mem_write_data_d;
      rdata_q <= rdata_d;
      resp_valid_q <= resp_valid_d;
`ifdef LSU_ERR_EN
      err_q <= err_d;
`endif
    end
  end

  assign req_ready = rst_n && state_q == IDLE;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign mem_read = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_address = mem_address_q;
  assign mem_write_data = mem_write_data_q;
`ifdef LSU_ERR_EN
  assign resp_err = err_q;
`endif
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed-vector bench for load_store_unit against a behavioural word RAM.
module tb_load_store_unit;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic req_valid = 1'b0, req_store = 1'b0, resp_ready = 1'b0;
  logic [2:0] req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic req_ready, resp_valid, mem_read, mem_write;
  logic [31:0] resp_rdata, mem_address, mem_write_data;
  logic [31:0] mem_read_data = '0;
`ifdef LSU_ERR_EN
  logic resp_err;
  logic last_err;
`endif
  logic [31:0] ram [0:63] = '{4: 32'h8899AABB, 8: 32'h11223344, default: 32'h0};
  int rd_cnt = 0, wr_cnt = 0, both_cnt = 0, errors = 0, checks = 0;
  int lat, r0, w0;
  logic [31:0] last_wa = '0, last_wd = '0, rdata;

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
`ifdef LSU_ERR_EN
    .resp_err(resp_err),
`endif
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  // Word RAM: read data appears the cycle after the read strobe
  always @(posedge clk) begin
    if (mem_read && mem_write) both_cnt++;
    if (mem_read) begin
      mem_read_data <= ram[mem_address[7:2]];
      rd_cnt++;
    end
    if (mem_write) begin
      ram[mem_address[7:2]] = mem_write_data;
      last_wa = mem_address;
      last_wd = mem_write_data;
      wr_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wait_resp();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 20);
    lat = n;
    rdata = resp_rdata;
`ifdef LSU_ERR_EN
    last_err = resp_err;
`endif
  endtask

  task automatic release_resp();
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  task automatic txn(input string tag, input logic st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input int exp_lat, input logic [31:0] exp_rd);
    @(negedge clk);
    check({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_store = st;
    req_funct3 = f3;
    req_addr = a;
    req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_resp();
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_rdata"}, rdata, exp_rd);
    release_resp();
  endtask

  initial begin
    #1;
    check("rst_ready", {31'b0, req_ready}, 32'd0);
    check("rst_strobes", {29'b0, resp_valid, mem_read, mem_write}, 32'd0);
    check("rst_addr", mem_address, 32'd0);
    check("rst_wdata", mem_write_data, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("rel_ready", {31'b0, req_ready}, 32'd1);

    txn("lb13", 1'b0, 3'b000, 32'h13, 32'h0, 3, 32'hFFFFFF88);
    txn("lbu13", 1'b0, 3'b100, 32'h13, 32'h0, 3, 32'h00000088);
    txn("lh12", 1'b0, 3'b001, 32'h12, 32'h0, 3, 32'hFFFF8899);
    txn("lbu11", 1'b0, 3'b100, 32'h11, 32'h0, 3, 32'h000000AA);
    txn("lb10", 1'b0, 3'b000, 32'h10, 32'h0, 3, 32'hFFFFFFBB);

    r0 = rd_cnt; w0 = wr_cnt;
    txn("sh22", 1'b1, 3'b001, 32'h22, 32'h0000BEEF, 4, 32'h0);
    check("sh22_reads", rd_cnt - r0, 32'd1);
    check("sh22_writes", wr_cnt - w0, 32'd1);
    check("sh22_waddr", last_wa, 32'h20);
    check("sh22_wdata", last_wd, 32'hBEEF3344);
    txn("lw20", 1'b0, 3'b010, 32'h20, 32'h0, 3, 32'hBEEF3344);

    r0 = rd_cnt; w0 = wr_cnt;
    txn("sw40", 1'b1, 3'b010, 32'h40, 32'hDEADBEEF, 2, 32'h0);
    check("sw40_reads", rd_cnt - r0, 32'd0);
    check("sw40_writes", wr_cnt - w0, 32'd1);
    check("sw40_waddr", last_wa, 32'h40);
    check("sw40_ram", ram[16], 32'hDEADBEEF);
    txn("sb41", 1'b1, 3'b000, 32'h41, 32'hFFFFFF55, 4, 32'h0);
    check("sb41_ram", ram[16], 32'hDEAD55EF);

`ifdef LSU_ERR_EN
    r0 = rd_cnt; w0 = wr_cnt;
    txn("err_lw41", 1'b0, 3'b010, 32'h41, 32'h0, 1, 32'h0);
    check("err_lw41_err", {31'b0, last_err}, 32'd1);
    txn("err_lh43", 1'b0, 3'b001, 32'h43, 32'h0, 1, 32'h0);
    check("err_lh43_err", {31'b0, last_err}, 32'd1);
    txn("err_ld011", 1'b0, 3'b011, 32'h40, 32'h0, 1, 32'h0);
    check("err_ld011_err", {31'b0, last_err}, 32'd1);
    txn("err_st100", 1'b1, 3'b100, 32'h40, 32'h0, 1, 32'h0);
    check("err_st100_err", {31'b0, last_err}, 32'd1);
    txn("err_sw42", 1'b1, 3'b010, 32'h42, 32'h0, 1, 32'h0);
    check("err_sw42_err", {31'b0, last_err}, 32'd1);
    check("err_no_reads", rd_cnt - r0, 32'd0);
    check("err_no_writes", wr_cnt - w0, 32'd0);
    check("err_ram", ram[16], 32'hDEAD55EF);
    txn("ok_lbu13", 1'b0, 3'b100, 32'h13, 32'h0, 3, 32'h00000088);
    check("ok_lbu13_err", {31'b0, last_err}, 32'd0);
`else
    txn("al_lw41", 1'b0, 3'b010, 32'h41, 32'h0, 3, 32'hDEAD55EF);
    txn("al_lh43", 1'b0, 3'b001, 32'h43, 32'h0, 3, 32'hFFFFDEAD);
    txn("al_lhu41", 1'b0, 3'b101, 32'h41, 32'h0, 3, 32'h000055EF);
    txn("il_ld011", 1'b0, 3'b011, 32'h40, 32'h0, 3, 32'hDEAD55EF);
    r0 = rd_cnt;
    txn("il_st111", 1'b1, 3'b111, 32'h46, 32'h12345678, 2, 32'h0);
    check("il_st111_reads", rd_cnt - r0, 32'd0);
    check("il_st111_waddr", last_wa, 32'h44);
    check("il_st111_ram", ram[17], 32'h12345678);
`endif

    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b101; req_addr = 32'h10;
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_resp();
    check("bp_lat", lat, 32'd3);
    check("bp_rdata", rdata, 32'h0000AABB);
    r0 = rd_cnt;
    req_valid = 1'b1; req_funct3 = 3'b100; req_addr = 32'h13;
    repeat (5) begin
      @(negedge clk);
      check("bp_hold_valid", {31'b0, resp_valid}, 32'd1);
      check("bp_hold_rdata", resp_rdata, 32'h0000AABB);
      check("bp_hold_ready", {31'b0, req_ready}, 32'd0);
    end
    check("bp_no_read", rd_cnt - r0, 32'd0);
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    check("bp_idle_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_resp();
    check("bp2_lat", lat, 32'd3);
    check("bp2_rdata", rdata, 32'h00000088);
    release_resp();

    w0 = wr_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000; req_addr = 32'h20; req_wdata = 32'h77;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rw_write_phase", {31'b0, mem_write}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rw_strobes", {29'b0, resp_valid, mem_read, mem_write}, 32'd0);
    check("rw_addr", mem_address, 32'd0);
    check("rw_wdata", mem_write_data, 32'd0);
    check("rw_ready", {31'b0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("rw_no_write", wr_cnt - w0, 32'd0);
    check("rw_ram", ram[8], 32'hBEEF3344);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rw_rel_ready", {31'b0, req_ready}, 32'd1);
    txn("rw_lw20", 1'b0, 3'b010, 32'h20, 32'h0, 3, 32'hBEEF3344);

    check("mutex", both_cnt, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
